// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Instruction memory for cpu_core. It has two ports:
//   * Fetch port. The read latency is one cycle. Misaligned or out-of-range
//     addresses return NOP_INST with a fault flag.
//   * Byte-serial load port. Little-endian bytes are packed into 32-bit words
//     and written sequentially from a start address.
// While a load session is active, fetches return NOP_INST without ack, so the
// core stalls harmlessly.
//
// Ports:
//   clk_i-style naming is not used here; the port list is fixed:
//   clk             rising-edge clock
//   rst             synchronous active-low reset
//   inst_mem_addr   fetch byte address (64b)
//   inst_mem_valid  fetch request
//   inst_mem_data   fetched word (registered)
//   inst_mem_ack    inst_mem_data holds a real fetch result
//   inst_mem_fault  last fetch was misaligned / out of range
//   ld_start        begin a load session (IDLE only)
//   ld_addr         session start byte address, bits [1:0] ignored
//   ld_byte         load data byte
//   ld_byte_valid   ld_byte valid this cycle
//   ld_last         marks the final byte of the session
//   ld_busy         session in progress
//   ld_done         one-cycle pulse at session end
//   ld_count        words written in the current/last session
//   ld_overflow     sticky: session ran past the last word
// ---------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           inst_mem_addr,
    input  logic                  inst_mem_valid,
    output logic [31:0]           inst_mem_data,
    output logic                  inst_mem_ack,
    output logic                  inst_mem_fault,
    input  logic                  ld_start,
    input  logic [63:0]           ld_addr,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_byte_valid,
    input  logic                  ld_last,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic [DEPTH_LOG2:0]   ld_count,
    output logic                  ld_overflow
);

    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [63:0]       DEPTH_W = 64'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PTR_MAX = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_LOG2:0]    ptr_q, ptr_d;
    logic [1:0]             lane_q, lane_d;
    logic [31:0]            asm_q, asm_d;
    logic [DEPTH_LOG2:0]    cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [31:0]            data_q;
    logic                   ack_q, fault_q;

    logic [31:0]            mem [DEPTH];

    // Fetch address decode
    logic [63:0]            fetch_off;
    logic                   fetch_bad;
    logic [DEPTH_LOG2-1:0]  fetch_idx;

    assign fetch_off = inst_mem_addr - BASE_ADDR;
    assign fetch_bad = (inst_mem_addr[1:0] != 2'b00) || (fetch_off >= (DEPTH_W << 2));
    assign fetch_idx = fetch_off[DEPTH_LOG2+1:2];

    // Load start pointer: an out-of-range start parks the pointer at DEPTH so
    // every word of the session is dropped and flagged as overflow.
    logic [63:0]            ld_off;
    logic [63:0]            ld_word_off;
    logic [DEPTH_LOG2:0]    start_ptr;

    assign ld_off      = ld_addr - BASE_ADDR;
    assign ld_word_off = ld_off >> 2;
    assign start_ptr   = (ld_word_off >= DEPTH_W) ? PTR_MAX
                                                  : {1'b0, ld_off[DEPTH_LOG2+1:2]};

    // Byte merge: the assembly register is zero outside filled lanes, so a
    // word committed early by ld_last is zero-filled automatically.
    logic [31:0]            merged;
    logic                   ptr_in_range;

    assign merged       = asm_q | ({24'b0, ld_byte} << {lane_q, 3'b000});
    assign ptr_in_range = (ptr_q < PTR_MAX);

    // Control signals decoded from state (output process)
    logic                   start_take;
    logic                   byte_take;
    logic                   commit;
    logic                   mem_we;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ld_start)                      state_d = ST_LOAD;
            ST_LOAD: if (ld_byte_valid && ld_last)      state_d = ST_DONE;
            ST_DONE:                                    state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / control decode
    // ------------------------------------------------------------------
    always_comb begin
        start_take = 1'b0;
        byte_take  = 1'b0;
        ld_busy    = 1'b0;
        ld_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: start_take = ld_start;
            ST_LOAD: begin
                ld_busy   = 1'b1;
                byte_take = ld_byte_valid;
            end
            ST_DONE: ld_done = 1'b1;
            default: ;
        endcase
    end

    assign commit = byte_take && ((lane_q == 2'd3) || ld_last);
    // A reset in the same cycle as a commit abandons that word as well.
    assign mem_we = commit && ptr_in_range && rst;

    // ------------------------------------------------------------------
    // Load datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d  = ptr_q;
        lane_d = lane_q;
        asm_d  = asm_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (start_take) begin
            ptr_d  = start_ptr;
            lane_d = 2'd0;
            asm_d  = 32'h0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (byte_take) begin
            if (commit) begin
                if (ptr_in_range) begin
                    cnt_d = cnt_q + 1'b1;
                    ptr_d = ptr_q + 1'b1;   // stops at DEPTH, never wraps
                end else begin
                    ovf_d = 1'b1;
                end
                lane_d = 2'd0;
                asm_d  = 32'h0;
            end else begin
                lane_d = lane_q + 2'd1;
                asm_d  = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q  <= '0;
            lane_q <= 2'd0;
            asm_q  <= 32'h0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            lane_q <= lane_d;
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory write (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[DEPTH_LOG2-1:0]] <= merged;
        end
    end

    // ------------------------------------------------------------------
    // Fetch read: one-cycle latency. Reads only happen in IDLE, so they
    // never coincide with a write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= NOP_INST;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else if (inst_mem_valid && state_q == ST_IDLE) begin
            ack_q   <= 1'b1;
            fault_q <= fetch_bad;
            data_q  <= fetch_bad ? NOP_INST : mem[fetch_idx];
        end else if (inst_mem_valid) begin
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
            data_q  <= NOP_INST;
        end else begin
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end
    end

    assign inst_mem_data  = data_q;
    assign inst_mem_ack   = ack_q;
    assign inst_mem_fault = fault_q;
    assign ld_count       = cnt_q;
    assign ld_overflow    = ovf_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
// Self-checking bench for inst_mem_loader: load sessions, a fetch vector
// table, and hand-written sequences for faults, overflow and reset mid-load.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int          DL  = 10;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk;
    logic          rst;
    logic [63:0]   inst_mem_addr;
    logic          inst_mem_valid;
    logic [31:0]   inst_mem_data;
    logic          inst_mem_ack;
    logic          inst_mem_fault;
    logic          ld_start;
    logic [63:0]   ld_addr;
    logic [7:0]    ld_byte;
    logic          ld_byte_valid;
    logic          ld_last;
    logic          ld_busy;
    logic          ld_done;
    logic [DL:0]   ld_count;
    logic          ld_overflow;

    inst_mem_loader #(
        .DEPTH_LOG2 (DL),
        .BASE_ADDR  (64'h0),
        .NOP_INST   (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_valid (inst_mem_valid),
        .inst_mem_data  (inst_mem_data),
        .inst_mem_ack   (inst_mem_ack),
        .inst_mem_fault (inst_mem_fault),
        .ld_start       (ld_start),
        .ld_addr        (ld_addr),
        .ld_byte        (ld_byte),
        .ld_byte_valid  (ld_byte_valid),
        .ld_last        (ld_last),
        .ld_busy        (ld_busy),
        .ld_done        (ld_done),
        .ld_count       (ld_count),
        .ld_overflow    (ld_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] addr;
        logic [31:0] data;
        logic        ack;
        logic        fault;
    } vec_t;

    vec_t vecs[7];
    vec_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch; the expectation goes through the scoreboard queue and
    // is compared when the result appears one cycle later.
    task automatic fetch(input string nm, input logic [63:0] a, input logic [31:0] d,
                         input logic ak, input logic ft);
        vec_t e;
        vec_t got;
        e.name = nm; e.addr = a; e.data = d; e.ack = ak; e.fault = ft;
        inst_mem_valid = 1'b1;
        inst_mem_addr  = a;
        sbq.push_back(e);
        step();
        inst_mem_valid = 1'b0;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            got = sbq.pop_front();
            chk({got.name, ".data"},  inst_mem_data,  got.data);
            chk({got.name, ".ack"},   inst_mem_ack,   got.ack);
            chk({got.name, ".fault"}, inst_mem_fault, got.fault);
        end
    endtask

    // Run a full load session. A stray byte is offered with ld_start (must be
    // ignored), and an ld_last without ld_byte_valid is offered before the
    // second byte (must be ignored). fetch_at >= 0 issues a fetch alongside
    // that byte index.
    task automatic do_load(input string nm, input logic [63:0] a, input logic [7:0] bq[$],
                           input int fetch_at, input int exp_cnt, input logic exp_ovf);
        ld_start = 1'b1; ld_addr = a; ld_byte = 8'hFF; ld_byte_valid = 1'b1; ld_last = 1'b0;
        step();
        chk({nm, ".busy_start"}, ld_busy, 1'b1);
        ld_start = 1'b0; ld_byte_valid = 1'b0;
        for (int i = 0; i < bq.size(); i++) begin
            if (i == 1) begin
                ld_last = 1'b1; ld_byte_valid = 1'b0;
                step();
                chk({nm, ".last_novalid_busy"}, ld_busy, 1'b1);
            end
            ld_byte = bq[i]; ld_byte_valid = 1'b1; ld_last = (i == bq.size() - 1);
            if (i == fetch_at) begin
                inst_mem_valid = 1'b1; inst_mem_addr = 64'h0;
            end
            step();
            if (i == fetch_at) begin
                inst_mem_valid = 1'b0;
                chk({nm, ".fetch_in_load.data"},  inst_mem_data,  NOP);
                chk({nm, ".fetch_in_load.ack"},   inst_mem_ack,   1'b0);
                chk({nm, ".fetch_in_load.fault"}, inst_mem_fault, 1'b0);
            end
            if (i == bq.size() - 1) begin
                chk({nm, ".done"},      ld_done, 1'b1);
                chk({nm, ".busy_done"}, ld_busy, 1'b0);
            end else begin
                chk({nm, ".no_done"}, ld_done, 1'b0);
            end
        end
        ld_byte_valid = 1'b0; ld_last = 1'b0;
        step();
        chk({nm, ".done_cleared"}, ld_done,     1'b0);
        chk({nm, ".count"},        ld_count,    exp_cnt);
        chk({nm, ".overflow"},     ld_overflow, exp_ovf);
    endtask

    initial begin
        logic [7:0] bq[$];

        vecs[0] = '{"f_addr0",   64'h0,                 32'h002080B3, 1'b1, 1'b0};
        vecs[1] = '{"f_addr4",   64'h4,                 32'h00100113, 1'b1, 1'b0};
        vecs[2] = '{"f_addr8",   64'h8,                 32'h44332211, 1'b1, 1'b0};
        vecs[3] = '{"f_addr12",  64'hC,                 32'h000000EE, 1'b1, 1'b0};
        vecs[4] = '{"f_misal",   64'h2,                 NOP,          1'b1, 1'b1};
        vecs[5] = '{"f_oor",     64'd4096,              NOP,          1'b1, 1'b1};
        vecs[6] = '{"f_oor_big", 64'hFFFF_FFFF_FFFF_FFFC, NOP,        1'b1, 1'b1};

        rst = 1'b0; inst_mem_addr = '0; inst_mem_valid = 1'b0;
        ld_start = 1'b0; ld_addr = '0; ld_byte = '0; ld_byte_valid = 1'b0; ld_last = 1'b0;

        // 1. Reset
        repeat (2) step();
        rst = 1'b1;
        chk("rst.data",  inst_mem_data,  NOP);
        chk("rst.ack",   inst_mem_ack,   1'b0);
        chk("rst.fault", inst_mem_fault, 1'b0);
        chk("rst.busy",  ld_busy,        1'b0);
        chk("rst.done",  ld_done,        1'b0);
        chk("rst.count", ld_count,       0);
        chk("rst.ovf",   ld_overflow,    1'b0);
        step();

        // 2. Two full words at address 0
        bq = '{8'hB3, 8'h80, 8'h20, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        do_load("load0", 64'h0, bq, -1, 2, 1'b0);

        // 3. Partial final word at address 8
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEE};
        do_load("load8", 64'h8, bq, -1, 2, 1'b0);

        // Fetch vector table (data and faults)
        for (int i = 0; i < 7; i++)
            fetch(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].fault);

        // Data holds when no fetch is requested
        fetch("f_pre_hold", 64'hC, 32'h000000EE, 1'b1, 1'b0);
        step();
        chk("hold.data",  inst_mem_data,  32'h000000EE);
        chk("hold.ack",   inst_mem_ack,   1'b0);
        chk("hold.fault", inst_mem_fault, 1'b0);

        // 4. Fetch during a load returns NOP without ack
        bq = '{8'h55, 8'h66, 8'h77, 8'h88};
        do_load("load16", 64'h10, bq, 2, 1, 1'b0);
        fetch("f_addr16", 64'h10, 32'h88776655, 1'b1, 1'b0);

        // 5. Overflow at the last word; word 0 untouched
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load("load_ovf", 64'd4092, bq, -1, 1, 1'b1);
        fetch("f_last_word", 64'd4092, 32'h04030201, 1'b1, 1'b0);
        fetch("f_word0_ovf", 64'h0,    32'h002080B3, 1'b1, 1'b0);

        // Out-of-range start: everything dropped
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_load("load_oor", 64'd4096, bq, -1, 0, 1'b1);
        fetch("f_word0_oor", 64'h0, 32'h002080B3, 1'b1, 1'b0);

        // 6. Reset mid-load
        ld_start = 1'b1; ld_addr = 64'h0;
        step();
        ld_start = 1'b0;
        ld_byte = 8'hAA; ld_byte_valid = 1'b1;
        step();
        ld_byte = 8'hBB;
        step();
        chk("midrst.busy_before", ld_busy, 1'b1);
        ld_byte_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("midrst.busy",  ld_busy,  1'b0);
        chk("midrst.done",  ld_done,  1'b0);
        chk("midrst.count", ld_count, 0);
        rst = 1'b1;
        step();
        chk("midrst.done_after", ld_done, 1'b0);
        chk("midrst.busy_after", ld_busy, 1'b0);
        fetch("f_word0_rst", 64'h0, 32'h002080B3, 1'b1, 1'b0);
        fetch("f_word1_rst", 64'h4, 32'h00100113, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
